uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and the bit timing common
// to the sensor-board receiver and this transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE  = 3'b000,
    s_START = 3'b001,
    s_DATA  = 3'b010,
    s_STOP  = 3'b011
  } tx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
  localparam int unsigned MID_BIT              = 108;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding buffer so consecutive frames
// can be sent with no idle gap between stop bit and the next start bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       buf_data, buf_data_n;
  logic             buf_full, buf_full_n;
  logic             serial_n, active_n, done_n;
  logic             accept;

  assign accept = i_Tx_DV && !buf_full;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state       <= s_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      buf_data    <= buf_data_n;
      buf_full    <= buf_full_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Ready  <= !buf_full_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    done_n     = 1'b0;

    // Outside IDLE an accepted byte can only go to the holding buffer.
    if (accept && state != s_IDLE) begin
      buf_data_n = i_Tx_Byte;
      buf_full_n = 1'b1;
    end

    case (state)
      s_IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (buf_full) begin
          shift_n    = buf_data;
          buf_full_n = 1'b0;
          state_n    = s_START;
        end else if (accept) begin
          shift_n = i_Tx_Byte;
          state_n = s_START;
        end
      end

      s_START: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = s_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      s_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = s_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      s_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          // Only a byte buffered before this edge chains straight into START.
          if (buf_full) begin
            shift_n    = buf_data;
            buf_full_n = 1'b0;
            state_n    = s_START;
          end else begin
            state_n = s_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n   = s_IDLE;
        cnt_n     = '0;
        bit_idx_n = '0;
      end
    endcase
  end

  // Line level is derived from the next state so the output is registered
  // yet still changes on the same edge as the state.
  always_comb begin
    serial_n = 1'b1;
    active_n = 1'b1;
    case (state_n)
      s_START: serial_n = 1'b0;
      s_DATA:  serial_n = shift_n[bit_idx_n];
      s_STOP:  serial_n = 1'b1;
      default: begin
        serial_n = 1'b1;
        active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scenario bench for uart_tx: a loopback receiver pops expected bytes from a
// scoreboard queue, and each task checks line timing for its own scenario.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 217;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       dv;
  logic [7:0] byte_in;
  logic       ready;
  logic       active;
  logic       serial;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int act_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_Tx_DV    (dv),
    .i_Tx_Byte  (byte_in),
    .o_Tx_Ready (ready),
    .o_Tx_Active(active),
    .o_Tx_Serial(serial),
    .o_Tx_Done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (active === 1'b1) act_cnt++;
  end

  // Loopback receiver sampling mid-bit, same timing as the board receiver.
  logic       rx_busy = 1'b0;
  int         rx_c    = 0;
  logic [7:0] rx_data = '0;
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (serial === 1'b0) begin
        rx_busy = 1'b1;
        rx_c    = 0;
      end
    end else begin
      rx_c++;
      if (rx_c % CPB == int'(MID_BIT)) begin
        if (rx_c / CPB >= 1 && rx_c / CPB <= 8) begin
          rx_data[rx_c / CPB - 1] = serial;
        end else if (rx_c / CPB == 9) begin
          rx_busy = 1'b0;
          checks++;
          if (serial !== 1'b1) begin
            failures++;
            $display("FAIL rx_stop got=%b expected=1", serial);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected_frame got=%02h expected=none", rx_data);
          end else begin
            rx_exp = exp_q.pop_front();
            if (rx_data !== rx_exp) begin
              failures++;
              $display("FAIL rx_byte got=%02h expected=%02h", rx_data, rx_exp);
            end
          end
        end
      end
    end
  end

  // Returns just after the acceptance edge; the next negedge is frame cycle 0.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 dv = 1'b1;
    byte_in = b;
    @(posedge clk);
    #1 dv = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(output int waited);
    waited = 0;
    while (active !== 1'b0 && waited < 3 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    repeat (300) @(negedge clk);
  endtask

  task automatic test_reset;
    int bad_serial, bad_ready, bad_active, bad_done;
    rst = 1'b1;
    dv = 1'b0;
    byte_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({serial, ready, active, done} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b expected=1100", serial, ready, active, done);
    end
    bad_serial = 0; bad_ready = 0; bad_active = 0; bad_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (serial !== 1'b1) bad_serial++;
      if (ready !== 1'b1) bad_ready++;
      if (active !== 1'b0) bad_active++;
      if (done !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_serial != 0) begin failures++; $display("FAIL idle_serial bad_cycles=%0d expected=0", bad_serial); end
    checks++;
    if (bad_ready != 0) begin failures++; $display("FAIL idle_ready bad_cycles=%0d expected=0", bad_ready); end
    checks++;
    if (bad_active != 0) begin failures++; $display("FAIL idle_active bad_cycles=%0d expected=0", bad_active); end
    checks++;
    if (bad_done != 0) begin failures++; $display("FAIL idle_done bad_cycles=%0d expected=0", bad_done); end
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic       exp_bit;
    int bad[10];
    int done_bad, act_bad, ready_bad, w;
    b = 8'hA5;
    foreach (bad[k]) bad[k] = 0;
    done_bad = 0; act_bad = 0; ready_bad = 0;
    send_byte(b);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i / CPB == 0) exp_bit = 1'b0;
      else if (i / CPB == 9) exp_bit = 1'b1;
      else exp_bit = b[i / CPB - 1];
      if (serial !== exp_bit) bad[i / CPB]++;
      if (done !== 1'b0) done_bad++;
      if (active !== 1'b1) act_bad++;
      if (ready !== 1'b1) ready_bad++;
    end
    for (int p = 0; p < 10; p++) begin
      checks++;
      if (bad[p] != 0) begin
        failures++;
        $display("FAIL single_bit_period%0d bad_cycles=%0d expected=0", p, bad[p]);
      end
    end
    checks++;
    if (done_bad != 0) begin failures++; $display("FAIL single_done_early cycles=%0d expected=0", done_bad); end
    checks++;
    if (act_bad != 0) begin failures++; $display("FAIL single_active cycles=%0d expected=0", act_bad); end
    checks++;
    if (ready_bad != 0) begin failures++; $display("FAIL single_ready cycles=%0d expected=0", ready_bad); end
    @(negedge clk);
    checks++;
    if ({done, active, serial} !== 3'b101) begin
      failures++;
      $display("FAIL single_done_pulse got=%b%b%b expected=101", done, active, serial);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b expected=0", done); end
    wait_idle(w);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_scoreboard left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int d0, a0, i, w;
    d0 = done_cnt;
    a0 = act_cnt;
    send_byte(8'h00);
    i = -1;
    repeat (500) begin @(negedge clk); i++; end
    @(posedge clk);
    #1 dv = 1'b1;
    byte_in = 8'hFF;
    @(posedge clk);
    #1 dv = 1'b0;
    exp_q.push_back(8'hFF);
    i = 501;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop got=%b expected=0", ready); end
    while (i < FRAME - 1) begin @(negedge clk); i++; end
    checks++;
    if (serial !== 1'b1) begin failures++; $display("FAIL b2b_last_stop got=%b expected=1", serial); end
    @(negedge clk);
    checks++;
    if ({serial, done, active} !== 3'b011) begin
      failures++;
      $display("FAIL b2b_zero_gap got=%b%b%b expected=011", serial, done, active);
    end
    wait_idle(w);
    checks++;
    if (act_cnt - a0 != 2 * FRAME) begin
      failures++;
      $display("FAIL b2b_active_cycles got=%0d expected=%0d", act_cnt - a0, 2 * FRAME);
    end
    checks++;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_count got=%0d expected=2", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_scoreboard left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_buffer_full;
    int d0, n, w;
    d0 = done_cnt;
    send_byte(8'h12);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #1 dv = 1'b1;
    byte_in = 8'h34;
    @(posedge clk);
    #1 byte_in = 8'h56;
    exp_q.push_back(8'h34);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL full_ready_drop got=%b expected=0", ready); end
    repeat (5) @(posedge clk);
    #1 dv = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 2500) begin @(negedge clk); n++; end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_timeout got=%b expected=1", ready);
    end else begin
      checks++;
      if ({serial, done, active} !== 3'b011) begin
        failures++;
        $display("FAIL full_ready_at_frame2 got=%b%b%b expected=011", serial, done, active);
      end
    end
    wait_idle(w);
    checks++;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL full_done_count got=%0d expected=2", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL full_scoreboard left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, bad, w;
    send_byte(8'h3C);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #1 dv = 1'b1;
    byte_in = 8'h55;
    @(posedge clk);
    #1 dv = 1'b0;
    exp_q.push_back(8'h55);
    repeat (4 * CPB + 100 - 302) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({serial, ready, active, done} !== 4'b1100) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b%b%b%b expected=1100", serial, ready, active, done);
    end
    d0 = done_cnt;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (serial !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rstmid_no_frame bad_cycles=%0d expected=0", bad); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL rstmid_no_done got=%0d expected=0", done_cnt - d0); end
    send_byte(8'h81);
    @(negedge clk);
    checks++;
    if (serial !== 1'b0) begin failures++; $display("FAIL rstmid_restart got=%b expected=0", serial); end
    wait_idle(w);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL rstmid_done_count got=%0d expected=1", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_scoreboard left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_stop_edge;
    int d0, w;
    d0 = done_cnt;
    send_byte(8'hC3);
    repeat (FRAME - 1) @(negedge clk);
    @(posedge clk);
    #1 dv = 1'b1;
    byte_in = 8'h5A;
    @(posedge clk);
    #1 dv = 1'b0;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    checks++;
    if ({done, active, serial, ready} !== 4'b1010) begin
      failures++;
      $display("FAIL edge_idle_cycle got=%b%b%b%b expected=1010", done, active, serial, ready);
    end
    @(negedge clk);
    checks++;
    if ({done, active, serial, ready} !== 4'b0101) begin
      failures++;
      $display("FAIL edge_buffer_start got=%b%b%b%b expected=0101", done, active, serial, ready);
    end
    wait_idle(w);
    checks++;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL edge_done_count got=%0d expected=2", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL edge_scoreboard left=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    dv = 1'b0;
    byte_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_buffer_full();
    test_reset_mid_frame();
    test_stop_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
